// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: FSM state codes, round count,
// the Rcon table and the word slices of a 128-bit round key.
package aes_pkg;

    localparam int NR = 10;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;

    // Rcon[0] and the entries above NR never select a real constant; they read as zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam int W0_HI = 127;
    localparam int W0_LO = 96;
    localparam int W1_HI = 95;
    localparam int W1_LO = 64;
    localparam int W2_HI = 63;
    localparam int W2_LO = 32;
    localparam int W3_HI = 31;
    localparam int W3_LO = 0;

endpackage

// File: rtl/g_function.sv
// AES key-schedule g(): RotWord, SubWord, then Rcon XOR into the top byte.
module g_function
    import aes_pkg::*;
(
    input  logic [31:0] w,
    input  logic [3:0]  current_round,
    output logic [31:0] w_prime
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [31:0] rot_word;

    always_comb begin
        rot_word = {w[23:0], w[31:24]};
        w_prime  = {SBOX[rot_word[31:24]] ^ RCON[current_round],
                    SBOX[rot_word[23:16]],
                    SBOX[rot_word[15:8]],
                    SBOX[rot_word[7:0]]};
    end

endmodule

// File: rtl/inv_key_generator.sv
// AES-128 decryption key scheduler: expands forward to round 10, then walks
// the schedule backwards one round key per key_next request.
module inv_key_generator
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_text,
    input  logic         key_load,
    input  logic         key_next,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    output logic         busy
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0]   state;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  v3;
    logic [31:0]  g_in, g_out;
    logic [3:0]   g_round;
    logic [127:0] fwd_key, bwd_key;

    assign w0 = key_out[W0_HI:W0_LO];
    assign w1 = key_out[W1_HI:W1_LO];
    assign w2 = key_out[W2_HI:W2_LO];
    assign w3 = key_out[W3_HI:W3_LO];
    assign v3 = w3 ^ w2;

    // A single g() serves both directions: forward uses w3 and the next round,
    // backward uses the recovered previous w3 and the current round.
    always_comb begin
        g_in    = w3;
        g_round = key_round + 4'd1;
        if (state == READY) begin
            g_in    = v3;
            g_round = key_round;
        end
    end

    g_function u_g_function (
        .w             (g_in),
        .current_round (g_round),
        .w_prime       (g_out)
    );

    always_comb begin
        fwd_key[W0_HI:W0_LO] = w0 ^ g_out;
        fwd_key[W1_HI:W1_LO] = w1 ^ fwd_key[W0_HI:W0_LO];
        fwd_key[W2_HI:W2_LO] = w2 ^ fwd_key[W1_HI:W1_LO];
        fwd_key[W3_HI:W3_LO] = w3 ^ fwd_key[W2_HI:W2_LO];

        bwd_key[W3_HI:W3_LO] = v3;
        bwd_key[W2_HI:W2_LO] = w2 ^ w1;
        bwd_key[W1_HI:W1_LO] = w1 ^ w0;
        bwd_key[W0_HI:W0_LO] = w0 ^ g_out;
    end

    // key_load restarts from any state and beats a simultaneous key_next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_out   <= '0;
            key_round <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (key_load) begin
            state     <= EXPAND;
            key_out   <= key_text;
            key_round <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                EXPAND: begin
                    key_out   <= fwd_key;
                    key_round <= g_round;
                    if (g_round == LAST_ROUND) begin
                        state     <= READY;
                        busy      <= 1'b0;
                        key_valid <= 1'b1;
                    end
                end
                READY: begin
                    if (key_next) begin
                        if (key_round != 4'd0) begin
                            key_out   <= bwd_key;
                            key_round <= key_round - 4'd1;
                        end else begin
                            state     <= IDLE;
                            key_valid <= 1'b0;
                        end
                    end
                end
                IDLE: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_key_generator.sv
// Self-checking bench for inv_key_generator: FIPS-197 vectors plus random
// load/next traffic against a table-based key-schedule model.
module tb_inv_key_generator;

    logic         clk;
    logic         rst;
    logic [127:0] key_text;
    logic         key_load;
    logic         key_next;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         busy;

    inv_key_generator dut (
        .clk       (clk),
        .rst       (rst),
        .key_text  (key_text),
        .key_load  (key_load),
        .key_next  (key_next),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [7:0]   sboxModel [0:255];
    logic [127:0] keysModel [0:10];

    // Expected outputs; phase 0 = idle, 1 = expanding, 2 = reading out.
    int           modelPhase;
    int           modelRound;
    logic [127:0] modelOut;
    logic         modelValid;
    logic         modelBusy;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
    task automatic buildSbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sboxModel[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic expandKey(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sboxModel[t[31:24]], sboxModel[t[23:16]], sboxModel[t[15:8]], sboxModel[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) keysModel[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".key_out"},   key_out, modelOut);
        checkOutput({tag, ".key_round"}, 128'(key_round), 128'(modelRound));
        checkOutput({tag, ".key_valid"}, 128'(key_valid), 128'(modelValid));
        checkOutput({tag, ".busy"},      128'(busy), 128'(modelBusy));
    endtask

    task automatic modelReset();
        modelPhase = 0;
        modelRound = 0;
        modelOut   = '0;
        modelValid = 1'b0;
        modelBusy  = 1'b0;
    endtask

    task automatic modelStep(input logic load, input logic next, input logic [127:0] text);
        if (load) begin
            expandKey(text);
            modelPhase = 1;
            modelRound = 0;
            modelOut   = text;
            modelValid = 1'b0;
            modelBusy  = 1'b1;
        end else if (modelPhase == 1) begin
            modelRound++;
            modelOut = keysModel[modelRound];
            if (modelRound == 10) begin
                modelPhase = 2;
                modelBusy  = 1'b0;
                modelValid = 1'b1;
            end
        end else if (modelPhase == 2 && next) begin
            if (modelRound > 0) begin
                modelRound--;
                modelOut = keysModel[modelRound];
            end else begin
                modelPhase = 0;
                modelValid = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, sample 1 ns after the rising edge.
    task automatic applyStimulus(input string tag, input logic load, input logic next, input logic [127:0] text);
        @(negedge clk);
        key_load = load;
        key_next = next;
        key_text = text;
        @(posedge clk);
        modelStep(load, next, text);
        #1;
        checkAll(tag);
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, '0);
    endtask

    task automatic pulseReset(input string tag);
        @(negedge clk);
        key_load = 1'b0;
        key_next = 1'b0;
        rst = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        key_text = '0;
        key_load = 1'b0;
        key_next = 1'b0;
        modelReset();
        buildSbox();
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("load_fips", 1'b1, 1'b0, FIPS_KEY);
        for (int i = 0; i < 9; i++) begin
            applyStimulus("expand", 1'b0, 1'b0, '0);
            checkOutput("busy_during_expand", 128'(busy), 128'(1));
        end
        applyStimulus("expand_last", 1'b0, 1'b0, '0);
        checkOutput("fips_r10", key_out, FIPS_R10);
        checkOutput("fips_r10_round", 128'(key_round), 128'(10));
        checkOutput("fips_r10_valid", 128'(key_valid), 128'(1));

        applyStimulus("next", 1'b0, 1'b1, '0);
        checkOutput("fips_r9", key_out, FIPS_R9);
        for (int i = 0; i < 8; i++) applyStimulus("next", 1'b0, 1'b1, '0);
        checkOutput("fips_r1", key_out, FIPS_R1);
        applyStimulus("next", 1'b0, 1'b1, '0);
        checkOutput("fips_r0", key_out, FIPS_KEY);
        checkOutput("fips_r0_round", 128'(key_round), 128'(0));

        applyStimulus("next_at_r0", 1'b0, 1'b1, '0);
        checkOutput("valid_drop", 128'(key_valid), 128'(0));
        applyStimulus("next_in_idle", 1'b0, 1'b1, '0);
        checkOutput("idle_hold_key", key_out, FIPS_KEY);

        applyStimulus("reload_fips", 1'b1, 1'b0, FIPS_KEY);
        idleCycles("expand2", 10);
        for (int i = 0; i < 5; i++) applyStimulus("down_to_r5", 1'b0, 1'b1, '0);
        checkOutput("at_round5", 128'(key_round), 128'(5));
        applyStimulus("load_beats_next", 1'b1, 1'b1, '0);
        checkOutput("load_wins_round", 128'(key_round), 128'(0));
        idleCycles("expand_zero", 10);
        checkOutput("zero_r10", key_out, ZERO_R10);
        checkOutput("zero_r10_round", 128'(key_round), 128'(10));

        for (int i = 1; i <= 12; i++) begin
            applyStimulus("held_next", 1'b0, 1'b1, '0);
            if (i <= 10) checkOutput($sformatf("held_round_%0d", i), 128'(key_round), 128'(10 - i));
            if (i == 11) checkOutput("held_valid_fall", 128'(key_valid), 128'(0));
        end
        checkOutput("held_r0_zero_key", key_out, 128'h0);

        applyStimulus("load_for_reset", 1'b1, 1'b0, FIPS_KEY);
        idleCycles("expand_pre_reset", 3);
        pulseReset("reset_mid_expand");
        applyStimulus("next_after_reset", 1'b0, 1'b1, '0);
        checkOutput("reset_out_zero", key_out, 128'h0);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulseReset("rand_reset");
            end else begin
                applyStimulus("random",
                              $urandom_range(0, 15) == 0,
                              1'($urandom_range(0, 1)),
                              {$urandom, $urandom, $urandom, $urandom});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
